// File: rtl/prev_prime_if.sv
// Request/result bundle for prev_prime: start strobe and ceiling in, prime result and status out.
interface prev_prime_if;
  logic       findPrimeEnable;
  logic [6:0] primeNumberInput;
  logic [6:0] primeNumberOutput;
  logic       busy;
  logic       done;

  modport master (
    output findPrimeEnable,
    output primeNumberInput,
    input  primeNumberOutput,
    input  busy,
    input  done
  );

  modport slave (
    input  findPrimeEnable,
    input  primeNumberInput,
    output primeNumberOutput,
    output busy,
    output done
  );
endinterface

// File: rtl/prev_prime.sv
// Finds the largest prime <= a loaded ceiling by trial division with repeated subtraction.
// Define PREV_PRIME_SQRT_EN to stop trial division once factor*factor exceeds the candidate.
module prev_prime (
  input  logic         clk,
  input  logic         rst,
  prev_prime_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TEST  = 2'd1;
  localparam logic [1:0] DIV   = 2'd2;
  localparam logic [1:0] FOUND = 2'd3;

  logic [1:0] state_q, state_d;
  logic [6:0] cand_q, cand_d;
  logic [6:0] factor_q, factor_d;
  logic [6:0] rem_q, rem_d;
  logic [6:0] out_q, out_d;
  logic       done_q, done_d;
  logic [6:0] load_cand;
  logic       prime_exit;

  // Ceilings outside 2..99 wrap to the top of the window.
  assign load_cand = (bus.primeNumberInput >= 7'd2 && bus.primeNumberInput <= 7'd99) ?
                     bus.primeNumberInput : 7'd99;

`ifdef PREV_PRIME_SQRT_EN
  logic [13:0] factor_sq;
  assign factor_sq  = {7'd0, factor_q} * {7'd0, factor_q};
  assign prime_exit = factor_sq > {7'd0, cand_q};
`else
  assign prime_exit = factor_q >= cand_q;
`endif

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    factor_d = factor_q;
    rem_d    = rem_q;
    out_d    = out_q;
    done_d   = 1'b0;

    if (bus.findPrimeEnable) begin
      // A new request always wins, silently abandoning any search in flight.
      cand_d   = load_cand;
      factor_d = 7'd2;
      state_d  = TEST;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        TEST: begin
          if (prime_exit) begin
            state_d = FOUND;
          end else begin
            rem_d   = cand_q;
            state_d = DIV;
          end
        end
        DIV: begin
          if (rem_q == 7'd0) begin
            cand_d   = cand_q - 7'd1;
            factor_d = 7'd2;
            state_d  = TEST;
          end else if (rem_q >= factor_q) begin
            rem_d = rem_q - factor_q;
          end else begin
            factor_d = factor_q + 7'd1;
            state_d  = TEST;
          end
        end
        FOUND: begin
          out_d   = cand_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cand_q   <= 7'd0;
      factor_q <= 7'd2;
      rem_q    <= 7'd0;
      out_q    <= 7'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      factor_q <= factor_d;
      rem_q    <= rem_d;
      out_q    <= out_d;
      done_q   <= done_d;
    end
  end

  assign bus.primeNumberOutput = out_q;
  assign bus.done              = done_q;
  assign bus.busy              = (state_q != IDLE);

endmodule

// File: tb/tb_prev_prime.sv
// Self-checking bench for prev_prime: vector table, full input sweep against a trial-division
// model, plus abort and mid-search reset sequences.
module tb_prev_prime;

  logic clk;
  logic rst;

  prev_prime_if bus ();

  prev_prime dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] in;
    logic [6:0] exp;
  } vec_t;

  vec_t       vecs[12];
  logic [6:0] sb[$];
  int         checks   = 0;
  int         failures = 0;

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [6:0] golden(input int v);
    int c;
    c = (v < 2 || v > 99) ? 99 : v;
    while (!is_prime(c)) c--;
    return 7'(c);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge just after the sampling edge.
  task automatic start(input logic [6:0] v);
    bus.findPrimeEnable  = 1'b1;
    bus.primeNumberInput = v;
    @(negedge clk);
    bus.findPrimeEnable  = 1'b0;
  endtask

  // lat counts cycles from the sampling edge to the first cycle with done high.
  task automatic wait_result(input string name, input int max_cycles, output int lat);
    bit         seen;
    bit         busy_ok;
    logic [6:0] exp;
    seen    = 1'b0;
    busy_ok = 1'b1;
    lat     = 1;
    if (!bus.busy) busy_ok = 1'b0;
    while (!seen && lat < max_cycles) begin
      @(negedge clk);
      lat++;
      if (bus.done) seen = 1'b1;
      else if (!bus.busy) busy_ok = 1'b0;
    end
    check({name, " done_seen"}, int'(seen), 1);
    check({name, " busy_during_search"}, int'(busy_ok), 1);
    if (seen) begin
      if (sb.size() == 0) begin
        check({name, " scoreboard_nonempty"}, 0, 1);
      end else begin
        exp = sb.pop_front();
        check({name, " result"}, int'(bus.primeNumberOutput), int'(exp));
      end
      @(negedge clk);
      check({name, " done_single_pulse"}, int'(bus.done), 0);
      check({name, " busy_low_after"}, int'(bus.busy), 0);
    end
  endtask

  initial begin
    int  lat;
    int  lat_97;
    bit  quiet;
    logic [6:0] held;

    vecs[0]  = '{in: 7'd50,  exp: 7'd47};
    vecs[1]  = '{in: 7'd2,   exp: 7'd2};
    vecs[2]  = '{in: 7'd97,  exp: 7'd97};
    vecs[3]  = '{in: 7'd0,   exp: 7'd97};
    vecs[4]  = '{in: 7'd1,   exp: 7'd97};
    vecs[5]  = '{in: 7'd120, exp: 7'd97};
    vecs[6]  = '{in: 7'd3,   exp: 7'd3};
    vecs[7]  = '{in: 7'd4,   exp: 7'd3};
    vecs[8]  = '{in: 7'd99,  exp: 7'd97};
    vecs[9]  = '{in: 7'd100, exp: 7'd97};
    vecs[10] = '{in: 7'd127, exp: 7'd97};
    vecs[11] = '{in: 7'd25,  exp: 7'd23};

    rst                  = 1'b0;
    bus.findPrimeEnable  = 1'b0;
    bus.primeNumberInput = 7'd0;
    repeat (2) @(negedge clk);
    check("reset_output", int'(bus.primeNumberOutput), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    rst = 1'b1;

    // Idle after reset until a request arrives.
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy || bus.done) quiet = 1'b0;
    end
    check("idle_after_reset", int'(quiet), 1);

    foreach (vecs[i]) begin
      sb.push_back(vecs[i].exp);
      start(vecs[i].in);
      wait_result($sformatf("vec%0d_in%0d", i, vecs[i].in), 3000, lat);
      if (vecs[i].in == 7'd2) check("latency_cand2", lat, 3);
      if (vecs[i].in == 7'd97) lat_97 = lat;
    end

    // Result holds between searches.
    held = bus.primeNumberOutput;
    repeat (5) @(negedge clk);
    check("output_holds", int'(bus.primeNumberOutput), int'(held));

    // Restart mid-search: only the second request may complete.
    start(7'd90);
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) quiet = 1'b0;
    end
    check("abort_no_early_done", int'(quiet), 1);
    sb.push_back(7'd19);
    start(7'd20);
    wait_result("abort_restart_20", 3000, lat);
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) quiet = 1'b0;
    end
    check("abort_no_extra_done", int'(quiet), 1);

    // Reset mid-search clears outputs immediately and drops the search.
    start(7'd99);
    repeat (20) @(negedge clk);
    check("pre_reset_busy", int'(bus.busy), 1);
    rst = 1'b0;
    #1;
    check("midreset_output", int'(bus.primeNumberOutput), 0);
    check("midreset_busy", int'(bus.busy), 0);
    check("midreset_done", int'(bus.done), 0);
    repeat (3) @(negedge clk);
    rst   = 1'b1;
    quiet = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (bus.done || bus.busy) quiet = 1'b0;
    end
    check("post_reset_quiet", int'(quiet), 1);
    sb.push_back(7'd7);
    start(7'd10);
    wait_result("after_reset_10", 3000, lat);

    // Full sweep against the trial-division model.
    for (int v = 0; v < 128; v++) begin
      sb.push_back(golden(v));
      start(7'(v));
      wait_result($sformatf("sweep_%0d", v), 3000, lat);
      if (v == 97) check("sweep97_latency_repeatable", lat, lat_97);
    end

    check("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prev_prime.md
PREV_PRIME -- requirements
Module: prev_prime

Interface
REQ-001 The block SHALL have the following ports:
- clk  input  1  single rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- findPrimeEnable  input  1  start request, sampled on the clk rising edge.
- primeNumberInput  input  7  search ceiling, unsigned.
- primeNumberOutput  output  7  largest prime <= the loaded candidate; registered.
- busy  output  1  high while a search is in progress.
- done  output  1  single-cycle pulse when a new result is valid.

Function
REQ-002 FSM states SHALL be IDLE, TEST, DIV, FOUND.
REQ-003 Any state with findPrimeEnable=1 at a clk edge SHALL load the candidate, set factor=2, clear done and enter TEST.
- An in-progress search SHALL be aborted and restarted; no done pulse is issued for it.
REQ-004 Candidate load rule:
- primeNumberInput in 2..99: candidate = primeNumberInput.
- primeNumberInput 0, 1 or >99: candidate = 99 (wrap-around into the 2..99 window).
REQ-005 In TEST, if the prime-exit condition holds (REQ-013), the FSM SHALL go to FOUND.
- Otherwise it SHALL set remainder = candidate and go to DIV.
REQ-006 In DIV:
- Each cycle, remainder >= factor: remainder <= remainder - factor.
- remainder == 0: candidate is composite; candidate <= candidate - 1, factor <= 2, go to TEST.
- 0 < remainder < factor: factor <= factor + 1, go to TEST.
REQ-007 In FOUND: primeNumberOutput <= candidate, done <= 1 for exactly one cycle, go to IDLE.
REQ-008 busy SHALL be 1 in TEST, DIV and FOUND, and 0 in IDLE.
REQ-009 primeNumberOutput SHALL hold its value until the next FOUND.
REQ-010 Widths:
- candidate, factor and remainder are 7 bits.
- factor*factor is computed at 14 bits.
- Subtraction never underflows because it is guarded by remainder >= factor.
REQ-011 Candidate 2 SHALL be reported as prime. The candidate therefore never decrements below 2.
REQ-012 Latency from the sampling edge E:
- Candidate 2: done is high in the cycle after edge E+2.
- Other candidates: variable and bounded by the worst case for candidate 99.

Reset
REQ-013 (prime-exit condition) The condition is factor*factor > candidate with PREV_PRIME_SQRT_EN defined, and factor >= candidate without it (REQ-019).
REQ-014 rst=0 SHALL immediately force:
- state IDLE
- primeNumberOutput = 0
- busy = 0
- done = 0
- candidate = 0
- factor = 2
- remainder = 0
REQ-015 Reset asserted mid-search SHALL discard the search; no done pulse follows.
REQ-016 After rst deasserts, the block SHALL stay in IDLE until findPrimeEnable=1 is sampled.

Configuration
REQ-017 The macro PREV_PRIME_SQRT_EN SHALL select the prime-exit test.
REQ-018 Defined: a prime is declared when factor*factor > candidate (early square-root termination).
REQ-019 Undefined: a prime is declared only when factor >= candidate; the 14-bit multiply is not built.
REQ-020 primeNumberOutput SHALL be identical in both builds; only latency differs.

Verification
REQ-021 Input 50, single enable pulse -> done pulses once, primeNumberOutput=47, busy low afterwards.
REQ-022 Input 2 -> done high in the cycle after edge E+2, output 2; input 97 -> output 97.
REQ-023 Inputs 0, 1 and 120 -> output 97 each; busy high throughout each search.
REQ-024 Input 90, then enable with input 20 re-asserted mid-search -> one done pulse only, output 19.
REQ-025 Input 99, rst pulled low mid-search -> outputs zero immediately; no done pulse; after release, enable with input 10 -> output 7.
REQ-026 Sweep inputs 0..127 in both macro builds -> results match a golden largest-prime-<=-candidate model; the SQRT build never takes more cycles.
